// File: rtl/cpu_register_file_mp_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
package cpu_register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH          = 4;
  localparam int DEFAULT_NUMBER_OF_REGISTERS = 8;
  localparam int DEFAULT_AW                  = $clog2(DEFAULT_NUMBER_OF_REGISTERS);

  typedef logic [DEFAULT_AW-1:0]                reg_addr_t;
  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REGISTER = '0;

endpackage

// File: rtl/cpu_register_file_mp_if.sv
// Issue/writeback/read bus of cpu_register_file_mp; master = issue and writeback side.
interface cpu_register_file_mp_if
  import cpu_register_file_pkg::*;
#(
  parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int NUM_READ_PORTS      = 2,
  parameter int NUM_WRITE_PORTS     = 2
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic [NUM_WRITE_PORTS-1:0]            write_enable_in;
  logic [NUM_WRITE_PORTS*AW-1:0]         write_register_address_in;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data_in;
  logic [NUM_READ_PORTS*AW-1:0]          read_register_address_in;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data_out;
  logic [NUM_READ_PORTS-1:0]             read_busy_out;
  logic                                  reserve_enable_in;
  logic [AW-1:0]                         reserve_register_address_in;
  logic                                  reserve_conflict_out;
  logic [AW:0]                           busy_count_out;

  modport master (
    output write_enable_in, write_register_address_in, write_data_in,
    output read_register_address_in, reserve_enable_in, reserve_register_address_in,
    input  read_data_out, read_busy_out, reserve_conflict_out, busy_count_out
  );

  modport slave (
    input  write_enable_in, write_register_address_in, write_data_in,
    input  read_register_address_in, reserve_enable_in, reserve_register_address_in,
    output read_data_out, read_busy_out, reserve_conflict_out, busy_count_out
  );

endinterface

// File: rtl/cpu_register_file_mp_scoreboard.sv
// Busy-bit scoreboard: reserve sets, writeback clears, reserve wins on a same-cycle tie.
module register_scoreboard
  import cpu_register_file_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int AW                  = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUMBER_OF_REGISTERS-1:0] clear_mask,
  input  logic                           reserve_enable,
  input  logic [AW-1:0]                  reserve_address,
  output logic [NUMBER_OF_REGISTERS-1:0] busy,
  output logic                           conflict,
  output logic [AW:0]                    busy_count
);
  localparam int CW = AW + 1;

  logic                           reserve_valid;
  logic [NUMBER_OF_REGISTERS-1:0] set_mask;
  logic [NUMBER_OF_REGISTERS-1:0] busy_next;
  logic                           conflict_next;
  logic [AW:0]                    count_next;

  always_comb begin
    reserve_valid = reserve_enable && (reserve_address != '0);
    set_mask      = '0;
    if (reserve_valid) set_mask[reserve_address] = 1'b1;
    busy_next    = (busy & ~clear_mask) | set_mask;
    busy_next[0] = 1'b0;
    // A writeback landing on the reserved register in the same cycle retires the old producer.
    conflict_next = reserve_valid && busy[reserve_address] && !clear_mask[reserve_address];
    count_next = '0;
    for (int unsigned i = 0; i < NUMBER_OF_REGISTERS; i++)
      count_next = count_next + CW'(busy_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      conflict   <= 1'b0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      conflict   <= conflict_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/cpu_register_file_mp.sv
// Parametrised multi-port register file with r0 hardwired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module cpu_register_file_mp
  import cpu_register_file_pkg::*;
#(
  parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
  parameter int NUM_READ_PORTS      = 2,
  parameter int NUM_WRITE_PORTS     = 2
) (
  input logic                    clock_in,
  input logic                    reset_in,
  cpu_register_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic [DATA_WIDTH-1:0]          regs     [NUMBER_OF_REGISTERS];
  logic [DATA_WIDTH-1:0]          reg_view [NUMBER_OF_REGISTERS];
  logic [NUMBER_OF_REGISTERS-1:0] wr_hit;
  logic [DATA_WIDTH-1:0]          wr_val   [NUMBER_OF_REGISTERS];
  logic [NUMBER_OF_REGISTERS-1:0] busy;

  // Per-register write decode; the later port overrides, so the highest index wins.
  always_comb begin
    logic [AW-1:0] wa;
    wa     = '0;
    wr_hit = '0;
    for (int unsigned r = 0; r < NUMBER_OF_REGISTERS; r++) wr_val[r] = '0;
    for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
      wa = bus.write_register_address_in[p*AW +: AW];
      if (bus.write_enable_in[p] && (wa != '0)) begin
        wr_hit[wa] = 1'b1;
        wr_val[wa] = bus.write_data_in[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned r = 0; r < NUMBER_OF_REGISTERS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NUMBER_OF_REGISTERS; r++)
        if (wr_hit[r]) regs[r] <= wr_val[r];
    end
  end

  for (genvar g = 0; g < NUMBER_OF_REGISTERS; g++) begin : gen_reg
    logic [DATA_WIDTH-1:0] value;
    assign value       = regs[g];
    assign reg_view[g] = value;
  end

  register_scoreboard #(
    .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
    .AW                  (AW)
  ) u_scoreboard (
    .clk             (clock_in),
    .rst             (reset_in),
    .clear_mask      (wr_hit),
    .reserve_enable  (bus.reserve_enable_in),
    .reserve_address (bus.reserve_register_address_in),
    .busy            (busy),
    .conflict        (bus.reserve_conflict_out),
    .busy_count      (bus.busy_count_out)
  );

  always_comb begin
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;
    ra = '0;
    rd = '0;
    rb = 1'b0;
    bus.read_data_out = '0;
    bus.read_busy_out = '0;
    for (int unsigned rp = 0; rp < NUM_READ_PORTS; rp++) begin
      ra = bus.read_register_address_in[rp*AW +: AW];
      rd = reg_view[ra];
      rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit[ra]) begin
        rd = wr_val[ra];
        rb = 1'b0;
      end
`endif
      bus.read_data_out[rp*DATA_WIDTH +: DATA_WIDTH] = rd;
      bus.read_busy_out[rp]                          = rb;
    end
  end

endmodule

// File: tb/tb_cpu_register_file_mp.sv
// Directed checks on the default configuration, then random traffic on an 8-bit/16-entry/3R2W build.
module tb_cpu_register_file_mp;
  import cpu_register_file_pkg::*;

  localparam int BW = 8, BN = 16, BR = 3, BP = 2, BA = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  cpu_register_file_mp_if #(.DATA_WIDTH(4), .NUMBER_OF_REGISTERS(8),
                            .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2)) bus_a ();
  cpu_register_file_mp_if #(.DATA_WIDTH(BW), .NUMBER_OF_REGISTERS(BN),
                            .NUM_READ_PORTS(BR), .NUM_WRITE_PORTS(BP)) bus_b ();

  cpu_register_file_mp #(.DATA_WIDTH(4), .NUMBER_OF_REGISTERS(8),
                         .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2))
    dut_a (.clock_in(clk), .reset_in(rst), .bus(bus_a));

  cpu_register_file_mp #(.DATA_WIDTH(BW), .NUMBER_OF_REGISTERS(BN),
                         .NUM_READ_PORTS(BR), .NUM_WRITE_PORTS(BP))
    dut_b (.clock_in(clk), .reset_in(rst), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default-config helpers ----------------
  task automatic a_idle();
    bus_a.write_enable_in             = '0;
    bus_a.write_register_address_in   = '0;
    bus_a.write_data_in               = '0;
    bus_a.reserve_enable_in           = 1'b0;
    bus_a.reserve_register_address_in = '0;
  endtask

  task automatic a_wr(input int p, input int addr, input int data);
    bus_a.write_enable_in[p]                  = 1'b1;
    bus_a.write_register_address_in[p*3 +: 3] = 3'(addr);
    bus_a.write_data_in[p*4 +: 4]             = 4'(data);
  endtask

  task automatic a_rsv(input int addr);
    bus_a.reserve_enable_in           = 1'b1;
    bus_a.reserve_register_address_in = 3'(addr);
  endtask

  task automatic a_rd(input int p, input int addr);
    bus_a.read_register_address_in[p*3 +: 3] = 3'(addr);
  endtask

  function automatic logic [3:0] a_data(input int p);
    return bus_a.read_data_out[p*4 +: 4];
  endfunction

  // ---------------- reference model for the random build ----------------
  logic [BW-1:0] m_mem  [BN];
  logic          m_busy [BN];
  logic          m_conf;
  int unsigned   m_cnt;

  task automatic m_reset();
    for (int r = 0; r < BN; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_conf = 1'b0;
    m_cnt  = 0;
  endtask

  // Applies one clock edge worth of the current bus_b inputs to the model.
  task automatic m_step();
    logic [BN-1:0] hit;
    int            wa, ra;
    logic          was_busy;
    hit = '0;
    for (int p = 0; p < BP; p++) begin
      wa = int'(bus_b.write_register_address_in[p*BA +: BA]);
      if (bus_b.write_enable_in[p] && wa != 0) begin
        m_mem[wa] = bus_b.write_data_in[p*BW +: BW];
        hit[wa]   = 1'b1;
      end
    end
    ra       = int'(bus_b.reserve_register_address_in);
    was_busy = m_busy[ra];
    for (int r = 0; r < BN; r++) if (hit[r]) m_busy[r] = 1'b0;
    m_conf = 1'b0;
    if (bus_b.reserve_enable_in && ra != 0) begin
      m_conf    = was_busy && !hit[ra];
      m_busy[ra] = 1'b1;
    end
    m_cnt = 0;
    for (int r = 0; r < BN; r++) m_cnt += int'(m_busy[r]);
  endtask

  function automatic logic [BW-1:0] exp_data(input int a);
    logic [BW-1:0] v;
    v = (a == 0) ? '0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < BP; p++)
      if (a != 0 && bus_b.write_enable_in[p] &&
          int'(bus_b.write_register_address_in[p*BA +: BA]) == a)
        v = bus_b.write_data_in[p*BW +: BW];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < BP; p++)
      if (a != 0 && bus_b.write_enable_in[p] &&
          int'(bus_b.write_register_address_in[p*BA +: BA]) == a)
        b = 1'b0;
`endif
    return b;
  endfunction

  task automatic b_idle();
    bus_b.write_enable_in             = '0;
    bus_b.write_register_address_in   = '0;
    bus_b.write_data_in               = '0;
    bus_b.reserve_enable_in           = 1'b0;
    bus_b.reserve_register_address_in = '0;
    bus_b.read_register_address_in    = '0;
  endtask

  task automatic b_randomize();
    int pick;
    for (int p = 0; p < BP; p++) begin
      bus_b.write_enable_in[p]                    = 1'($urandom_range(0, 1));
      bus_b.write_register_address_in[p*BA +: BA] = BA'($urandom_range(0, BN-1));
      bus_b.write_data_in[p*BW +: BW]             = BW'($urandom);
    end
    bus_b.reserve_enable_in = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 3) == 0)
      bus_b.reserve_register_address_in = bus_b.write_register_address_in[0 +: BA];
    else
      bus_b.reserve_register_address_in = BA'($urandom_range(0, BN-1));
    for (int rp = 0; rp < BR; rp++) begin
      pick = int'($urandom_range(0, BP-1));
      if ($urandom_range(0, 1) == 1)
        bus_b.read_register_address_in[rp*BA +: BA] = bus_b.write_register_address_in[pick*BA +: BA];
      else
        bus_b.read_register_address_in[rp*BA +: BA] = BA'($urandom_range(0, BN-1));
    end
  endtask

  task automatic b_check_outputs();
    int a;
    for (int rp = 0; rp < BR; rp++) begin
      a = int'(bus_b.read_register_address_in[rp*BA +: BA]);
      check_eq("b_read_data", bus_b.read_data_out[rp*BW +: BW], exp_data(a));
      check_eq("b_read_busy", bus_b.read_busy_out[rp], exp_busy(a));
    end
    check_eq("b_busy_count", bus_b.busy_count_out, m_cnt);
    check_eq("b_conflict", bus_b.reserve_conflict_out, m_conf);
  endtask

  initial begin
    rst = 1'b1;
    a_idle();
    bus_a.read_register_address_in = '0;
    b_idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, every address on both ports
    for (int a = 0; a < 8; a++) begin
      a_rd(0, a);
      a_rd(1, 7 - a);
      #1;
      check_eq("a_reset_data0", a_data(0), 4'd0);
      check_eq("a_reset_data1", a_data(1), 4'd0);
      check_eq("a_reset_busy", bus_a.read_busy_out, 2'b00);
    end
    check_eq("a_reset_count", bus_a.busy_count_out, 4'd0);
    check_eq("a_reset_conflict", bus_a.reserve_conflict_out, 1'b0);
    tick();

    // Write r3=5, then reset mid-cycle with a write and a reserve pending
    a_wr(0, 3, 5);
    a_rsv(4);
    tick();
    a_idle();
    a_rd(0, 3);
    a_rd(1, 4);
    #1;
    check_eq("a_r3_written", a_data(0), 4'd5);
    check_eq("a_r4_busy_pre_reset", bus_a.read_busy_out[1], 1'b1);
    check_eq("a_count_pre_reset", bus_a.busy_count_out, 4'd1);
    a_wr(1, 1, 6);
    a_rsv(2);
    #2 rst = 1'b1;
    a_rd(1, 1);
    #1;
    check_eq("a_async_reset_r3", a_data(0), 4'd0);
    check_eq("a_async_reset_r1", a_data(1), 4'd0);
    check_eq("a_async_reset_count", bus_a.busy_count_out, 4'd0);
    check_eq("a_async_reset_conflict", bus_a.reserve_conflict_out, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    a_idle();
    a_rd(0, 2);
    #1;
    check_eq("a_discard_write_r1", a_data(1), 4'd0);
    check_eq("a_discard_reserve_r2", bus_a.read_busy_out[0], 1'b0);
    check_eq("a_post_reset_count", bus_a.busy_count_out, 4'd0);
    tick();

    // Writes to r0 are ignored
    a_wr(0, int'(ZERO_REGISTER), 7);
    tick();
    a_idle();
    a_rd(0, int'(ZERO_REGISTER));
    #1;
    check_eq("a_r0_data", a_data(0), 4'd0);
    check_eq("a_r0_busy", bus_a.read_busy_out[0], 1'b0);

    // Same-address collision: port 1 wins
    a_wr(0, 2, 3);
    a_wr(1, 2, -4);
    tick();
    a_idle();
    a_rd(0, 2);
    #1;
    check_eq("a_collision_r2", a_data(0), 4'b1100);

    // Forwarding: r5 holds 1 and is reserved, then written with 6 while read
    a_wr(0, 5, 1);
    tick();
    a_idle();
    a_rsv(5);
    tick();
    a_idle();
    a_wr(0, 5, 6);
    a_rd(1, 5);
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("a_bypass_data", a_data(1), 4'd6);
    check_eq("a_bypass_busy", bus_a.read_busy_out[1], 1'b0);
`else
    check_eq("a_nobypass_data", a_data(1), 4'd1);
    check_eq("a_nobypass_busy", bus_a.read_busy_out[1], 1'b1);
`endif
    tick();
    a_idle();
    #1;
    check_eq("a_r5_after_write", a_data(1), 4'd6);
    check_eq("a_r5_busy_cleared", bus_a.read_busy_out[1], 1'b0);

    // Scoreboard lifecycle on r4
    a_rsv(4);
    a_rd(0, 4);
    tick();
    a_idle();
    #1;
    check_eq("a_r4_busy_set", bus_a.read_busy_out[0], 1'b1);
    check_eq("a_count_one", bus_a.busy_count_out, 4'd1);
    a_wr(1, 4, 2);
    tick();
    a_idle();
    #1;
    check_eq("a_r4_busy_clear", bus_a.read_busy_out[0], 1'b0);
    check_eq("a_r4_data2", a_data(0), 4'd2);
    check_eq("a_count_zero", bus_a.busy_count_out, 4'd0);
    a_rsv(4);
    a_wr(0, 4, 3);
    tick();
    a_idle();
    #1;
    check_eq("a_reserve_wins_busy", bus_a.read_busy_out[0], 1'b1);
    check_eq("a_reserve_wins_data", a_data(0), 4'd3);
    check_eq("a_reserve_wins_conflict", bus_a.reserve_conflict_out, 1'b0);

    // WAW on r6, then a reserve of r0
    a_rsv(6);
    tick();
    check_eq("a_waw_first", bus_a.reserve_conflict_out, 1'b0);
    check_eq("a_count_two", bus_a.busy_count_out, 4'd2);
    tick();
    a_idle();
    #1;
    check_eq("a_waw_second", bus_a.reserve_conflict_out, 1'b1);
    check_eq("a_waw_count", bus_a.busy_count_out, 4'd2);
    tick();
    check_eq("a_waw_one_cycle", bus_a.reserve_conflict_out, 1'b0);
    a_rsv(0);
    tick();
    a_idle();
    #1;
    check_eq("a_r0_reserve_conflict", bus_a.reserve_conflict_out, 1'b0);
    check_eq("a_r0_reserve_count", bus_a.busy_count_out, 4'd2);
    // Reserve onto busy r4 cleared by a same-cycle write is not a conflict
    a_rsv(4);
    a_wr(1, 4, 1);
    tick();
    a_idle();
    #1;
    check_eq("a_cleared_reserve_conflict", bus_a.reserve_conflict_out, 1'b0);
    check_eq("a_cleared_reserve_busy", bus_a.read_busy_out[0], 1'b1);
    check_eq("a_cleared_reserve_count", bus_a.busy_count_out, 4'd2);

    // Wide build: r15 = -128, then random traffic with a reset in the middle
    b_idle();
    bus_b.write_enable_in[1]              = 1'b1;
    bus_b.write_register_address_in[BA +: BA] = BA'(15);
    bus_b.write_data_in[BW +: BW]         = 8'h80;
    m_step();
    tick();
    b_idle();
    bus_b.read_register_address_in[2*BA +: BA] = BA'(15);
    #1;
    check_eq("b_r15_neg128", bus_b.read_data_out[2*BW +: BW], 8'h80);
    b_check_outputs();

    for (int i = 0; i < 300; i++) begin
      b_randomize();
      #1;
      b_check_outputs();
      if (i == 150) begin
        rst = 1'b1;
        #1;
        check_eq("b_async_reset_count", bus_b.busy_count_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
      end else begin
        m_step();
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cpu_register_file_mp.md
# cpu_register_file_mp

Parametrised multi-port CPU register file with a per-register busy scoreboard. It generalises the single-write, dual-read 4-bit register file: data width, depth, and read/write port counts are parameters. It adds same-cycle write-to-read forwarding and tracks in-flight producers, so the tensor-core issue logic can detect RAW and WAW hazards. It sits between instruction decode/issue and the execute/writeback stages.

## Interface
Parameters:
- DATA_WIDTH, 4: bits per register, signed two's complement.
- NUMBER_OF_REGISTERS, 8: register count, power of two, at least 2.
- NUM_READ_PORTS, 2: independent combinational read ports, at least 1.
- NUM_WRITE_PORTS, 2: writeback ports, at least 1.
- AW, derived as $clog2(NUMBER_OF_REGISTERS): address width.

Ports:
- clock_in, input, 1: single clock, rising edge.
- reset_in, input, 1: asynchronous, active-high reset.
- write_enable_in, input, NUM_WRITE_PORTS: per-port write strobe.
- write_register_address_in, input, NUM_WRITE_PORTS*AW: packed; port p occupies bits [p*AW +: AW].
- write_data_in, input, NUM_WRITE_PORTS*DATA_WIDTH: packed, signed per lane.
- read_register_address_in, input, NUM_READ_PORTS*AW: packed.
- read_data_out, output, NUM_READ_PORTS*DATA_WIDTH: packed, signed per lane.
- read_busy_out, output, NUM_READ_PORTS: the addressed register has a pending producer.
- reserve_enable_in, input, 1: mark the destination register as busy (instruction issued).
- reserve_register_address_in, input, AW: destination being reserved.
- reserve_conflict_out, output, 1: registered flag for a WAW reserve onto an already-busy register.
- busy_count_out, output, AW+1: registered count of busy registers.

## Operation
- Register 0 is hardwired to zero.
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 with busy 0.
  - Reserves of address 0 are ignored and never set the conflict flag.
- Write: on a rising edge, each port p with write_enable_in[p]=1 and a nonzero address updates that register.
  - If several ports target the same address, the highest-index port wins.
- Read: read_data_out is combinational from the array.
- Scoreboard, one busy bit per register:
  - A reserve sets the busy bit.
  - Any enabled write to the address clears it.
  - A reserve and a write to the same address in the same cycle leave the bit set (reserve wins: a new producer is in flight).
  - A busy bit with no write pending stays set indefinitely; the block has no timeout.
- reserve_conflict_out is 1 for exactly the cycle after a reserve whose address was busy at that edge and was not cleared by a write in that same cycle; otherwise 0.
- busy_count_out equals the popcount of the busy bits after each edge, so it ranges from 0 to NUMBER_OF_REGISTERS-1.
- Reset, asserted at any time including mid-write:
  - all registers go to 0;
  - all busy bits go to 0;
  - reserve_conflict_out and busy_count_out go to 0;
  - pending writes and reserves in that cycle are discarded.
  - After reset, read_data_out is 0 and read_busy_out is 0 for every address.

## Timing
- Read data: zero-cycle combinational path from address (and, with bypass, from the write bus).
- Write data visible:
  - without bypass, on the read path the cycle after the edge;
  - with bypass, the same cycle.
- Busy set by a reserve at edge N is visible on read_busy_out from cycle N onward, immediately after the edge.
- reserve_conflict_out and busy_count_out reflect edge N during cycle N+1 and are registered.
- There is no handshake. Every strobe is single-cycle and is sampled at each rising edge.

## Configuration
- Macro REGFILE_BYPASS_EN.
  - Defined: a read port whose nonzero address matches an enabled write this cycle returns that write's data (highest-index port wins), and its read_busy_out is 0.
  - Not defined: reads return stored array contents only, and read_busy_out reflects the stored busy bit. Callers must wait one cycle after writeback.

## Structure
- Shared package cpu_register_file_pkg holds:
  - DEFAULT_DATA_WIDTH and DEFAULT_NUMBER_OF_REGISTERS;
  - typedef reg_addr_t (logic [AW-1:0] for the default depth);
  - typedef reg_data_t (logic signed [DEFAULT_DATA_WIDTH-1:0]);
  - the ZERO_REGISTER constant.
- One sub-module, register_scoreboard, is natural:
  - holds the busy vector, set/clear priority, conflict flag, and popcount;
  - is instantiated once, with read-port busy lookups and bypass masking done in the top.
- A generate loop exposes each register as a named wire for waveform debug.

## Test plan
- Reset and zero register:
  - assert reset mid-run after writing 5 to r3;
  - expect all reads 0, busy_count_out 0, reserve_conflict_out 0;
  - write 7 to r0 and expect r0 to read 0.
- Dual write collision (port0 writes r2=3, port1 writes r2=-4 in the same cycle):
  - next cycle, r2 reads -4 (4'b1100).
- Bypass:
  - write r5=6 while read port 1 addresses r5;
  - with REGFILE_BYPASS_EN, read_data_out lane1 = 6 in the same cycle;
  - without it, the old value, then 6 the following cycle.
- Scoreboard lifecycle:
  - reserve r4: read_busy r4 = 1 and busy_count_out = 1;
  - write r4=2: busy clears and count returns to 0;
  - reserve r4 and write r4 in the same cycle: busy stays 1.
- WAW conflict:
  - reserve r6 twice on consecutive cycles: reserve_conflict_out = 1 for exactly one cycle after the second reserve;
  - reserve r0: no conflict and count unchanged.
- Parameter sweep:
  - DATA_WIDTH=8, NUMBER_OF_REGISTERS=16, 3 read and 2 write ports;
  - random writes checked against a reference model, with r15=-128 read back correctly.
